clk_div_n_v3: RTL and testbench

Parametrised integer clock divider. Divides clkin by any runtime-programmable N in the range 2..2^DIV_W-1 and produces clkout at 50% duty for both even and odd N. Odd N uses a posedge/negedge pair. The divisor is changed glitch-free, at period boundaries only. Includes a clean start/stop enable and a period strobe for downstream counters in the clock-generation area.

---
 rtl/clk_div_n_v3.sv | 155 +++++++++++++++
 tb/tb_clk_div_n_v3.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_n_v3.sv
// Runtime-programmable integer clock divider with 50% duty for even and odd N.
// Divisor changes, start and stop all take effect only on period boundaries.
`timescale 1ns/1ps

module clk_div_n_v3 #(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 3
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic [DIV_W-1:0] cur_div,
    output logic             running,
    output logic             period_tick,
    output logic             clkout
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);

    state_t           state_q,      state_d;
    logic [DIV_W-1:0] cnt_q,        cnt_d;
    logic             pos_q,        pos_d;
    logic             neg_q;
    logic [DIV_W-1:0] cur_div_q,    cur_div_d;
    logic             odd_q,        odd_d;
    logic [DIV_W-1:0] pend_div_q,   pend_div_d;
    logic             pend_valid_q, pend_valid_d;
    logic             div_ack_q,    div_ack_d;
    logic             div_err_q,    div_err_d;
    logic             tick_q,       tick_d;

    logic [DIV_W-1:0] half;
    logic             at_wrap;
    logic             load_ok;
    logic             apply;

    assign half    = cur_div_q >> 1;
    assign at_wrap = (cnt_q == (cur_div_q - ONE));
    assign load_ok = div_load && (div_in >= TWO);

    // NOTE: every signal driven here gets its default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pos_d        = pos_q;
        cur_div_d    = cur_div_q;
        odd_d        = odd_q;
        pend_div_d   = pend_div_q;
        pend_valid_d = pend_valid_q;
        div_ack_d    = 1'b0;
        div_err_d    = div_load && (div_in < TWO);
        tick_d       = 1'b0;
        apply        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                pos_d = 1'b0;
                apply = pend_valid_q;
                // Start edge counts as the cnt==0 edge of the first period; N>=2 so H>=1.
                if (en) begin
                    state_d = ST_RUN;
                    cnt_d   = ONE;
                    pos_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            ST_RUN: begin
                tick_d = (cnt_q == '0);
                pos_d  = (cnt_q < half);
                if (at_wrap) begin
                    cnt_d = '0;
                    apply = pend_valid_q;
                    if (!en) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (apply) begin
            cur_div_d    = pend_div_q;
            odd_d        = pend_div_q[0];
            pend_valid_d = 1'b0;
            div_ack_d    = 1'b1;
        end

        // A load on the apply edge survives as the next pending divisor.
        if (load_ok) begin
            pend_div_d   = div_in;
            pend_valid_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pos_q        <= 1'b0;
            cur_div_q    <= DEF_N;
            odd_q        <= DEF_N[0];
            pend_div_q   <= DEF_N;
            pend_valid_q <= 1'b0;
            div_ack_q    <= 1'b0;
            div_err_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            cur_div_q    <= cur_div_d;
            odd_q        <= odd_d;
            pend_div_q   <= pend_div_d;
            pend_valid_q <= pend_valid_d;
            div_ack_q    <= div_ack_d;
            div_err_q    <= div_err_d;
            tick_q       <= tick_d;
        end
    end

    // Half-cycle extension flop. Qualifying with odd keeps a high captured under an
    // even N from stretching the first period after a switch to an odd N.
    always_ff @(negedge clkin) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q & odd_q;
        end
    end

    assign clkout      = pos_q | (odd_q & neg_q);
    assign div_ack     = div_ack_q;
    assign div_err     = div_err_q;
    assign cur_div     = cur_div_q;
    assign running     = (state_q == ST_RUN);
    assign period_tick = tick_q;

endmodule

// File: tb/tb_clk_div_n_v3.sv
// Bench for clk_div_n_v3: directed scenarios plus random traffic, checked every
// half-cycle against a period-level model keyed on absolute edge numbers.
`timescale 1ns/1ps

module tb_clk_div_n_v3;

    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 3;

    logic             clkin = 1'b0;
    logic             rst_n;
    logic             en;
    logic [DIV_W-1:0] div_in;
    logic             div_load;
    logic             div_ack;
    logic             div_err;
    logic [DIV_W-1:0] cur_div;
    logic             running;
    logic             period_tick;
    logic             clkout;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_n_v3 #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clkin       (clkin),
        .rst_n       (rst_n),
        .en          (en),
        .div_in      (div_in),
        .div_load    (div_load),
        .div_ack     (div_ack),
        .div_err     (div_err),
        .cur_div     (cur_div),
        .running     (running),
        .period_tick (period_tick),
        .clkout      (clkout)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Model: a period starting on edge s with divisor n is high for the first n
    // half-cycles of its 2n half-cycles; everything else follows the edge rules.
    int  e_cnt = 0;
    bit  m_ok  = 1'b0;
    bit  m_run, m_pv, x_ack, x_err, x_tick, skip_half;
    bit  boundary, apply;
    int  m_n, m_pn, nper, s_edge;

    function automatic logic [31:0] exp_clk(input int half_idx);
        int h;
        h = 2 * (e_cnt - s_edge) + half_idx;
        return (h >= 0 && h < nper) ? 32'd1 : 32'd0;
    endfunction

    always begin
        @(posedge clkin);
        e_cnt++;
        if (!rst_n) begin
            m_ok      = 1'b1;
            m_run     = 1'b0;
            m_n       = DEF_DIV;
            m_pv      = 1'b0;
            m_pn      = 0;
            s_edge    = -100000;
            nper      = 2;
            x_ack     = 1'b0;
            x_err     = 1'b0;
            x_tick    = 1'b0;
            skip_half = 1'b1;
        end else if (m_ok) begin
            skip_half = 1'b0;
            boundary  = m_run && (e_cnt - s_edge == nper - 1);
            apply     = m_pv && (!m_run || boundary);
            x_err     = div_load && (int'(div_in) < 2);
            x_ack     = apply;
            if (apply) begin
                m_n  = m_pn;
                m_pv = 1'b0;
            end
            if (div_load && int'(div_in) >= 2) begin
                m_pn = int'(div_in);
                m_pv = 1'b1;
            end
            if (!m_run) begin
                if (en) begin
                    m_run  = 1'b1;
                    s_edge = e_cnt;
                    nper   = m_n;
                end
            end else if (boundary) begin
                if (!en) begin
                    m_run = 1'b0;
                end else begin
                    s_edge = e_cnt + 1;
                    nper   = m_n;
                end
            end
            x_tick = m_run && (e_cnt == s_edge);
        end
        if (m_ok) begin
            #2;
            check("running",     32'(running),     32'(m_run));
            check("cur_div",     32'(cur_div),     32'(m_n));
            check("div_ack",     32'(div_ack),     32'(x_ack));
            check("div_err",     32'(div_err),     32'(x_err));
            check("period_tick", 32'(period_tick), 32'(x_tick));
            if (!skip_half) check("clkout_first_half", 32'(clkout), exp_clk(0));
            @(negedge clkin);
            #2;
            check("clkout_second_half", 32'(clkout), exp_clk(1));
        end
    end

    task automatic load(input int v);
        @(negedge clkin);
        div_in   = DIV_W'(v);
        div_load = 1'b1;
        @(negedge clkin);
        div_load = 1'b0;
    endtask

    // Leaves the caller 2ns after the posedge that raised period_tick.
    task automatic wait_tick(input string who);
        for (int k = 0; k < 600; k++) begin
            @(posedge clkin);
            #2;
            if (period_tick === 1'b1) return;
        end
        check(who, 32'd0, 32'd1);
    endtask

    task automatic measure(output int hi, output int tot);
        hi  = 0;
        tot = 0;
        wait_tick("measure_start_timeout");
        for (int k = 0; k < 600; k++) begin
            tot++;
            hi += (clkout === 1'b1) ? 1 : 0;
            @(negedge clkin);
            #2;
            tot++;
            hi += (clkout === 1'b1) ? 1 : 0;
            @(posedge clkin);
            #2;
            if (period_tick === 1'b1) return;
        end
        check("measure_end_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_stopped(output int cycles);
        cycles = 0;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clkin);
            #2;
            if (running === 1'b0) begin
                cycles = k;
                return;
            end
        end
        check("stop_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    int hi, tot, k;

    initial begin
        rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_in = '0;
        repeat (3) @(negedge clkin);
        rst_n = 1'b1;
        @(negedge clkin);
        check("reset_cur_div", 32'(cur_div), 32'd3);
        check("reset_running", 32'(running), 32'd0);
        check("reset_clkout",  32'(clkout),  32'd0);

        // Default N=3: 1.5 cycles high, 1.5 low.
        en = 1'b1;
        measure(hi, tot);
        check("n3_high_halves", 32'(hi), 32'd3);
        check("n3_period_halves", 32'(tot), 32'd6);

        // Mid-period load of 5 while running.
        load(5);
        measure(hi, tot);
        measure(hi, tot);
        check("n5_high_halves", 32'(hi), 32'd5);
        check("n5_period_halves", 32'(tot), 32'd10);

        // Rejected divisors.
        load(1);
        check("err_div1", 32'(div_err), 32'd1);
        load(0);
        check("err_div0", 32'(div_err), 32'd1);
        check("err_keeps_div", 32'(cur_div), 32'd5);
        measure(hi, tot);
        check("n5_after_err_period", 32'(tot), 32'd10);

        // Stop, then load 4 while stopped: applied on the next edge.
        en = 1'b0;
        wait_stopped(k);
        load(4);
        @(posedge clkin);
        #2;
        check("idle_load_ack", 32'(div_ack), 32'd1);
        check("idle_load_div", 32'(cur_div), 32'd4);
        @(negedge clkin);
        en = 1'b1;
        measure(hi, tot);
        check("n4_high_halves", 32'(hi), 32'd4);
        check("n4_period_halves", 32'(tot), 32'd8);

        // N=6, en dropped while cnt==1: five more edges finish the period.
        load(6);
        measure(hi, tot);
        measure(hi, tot);
        check("n6_period_halves", 32'(tot), 32'd12);
        @(negedge clkin);
        en = 1'b0;
        wait_stopped(k);
        check("n6_stop_latency", 32'(k), 32'd5);
        repeat (4) @(negedge clkin);
        check("stopped_clkout_low", 32'(clkout), 32'd0);
        en = 1'b1;
        measure(hi, tot);
        check("n6_restart_high_halves", 32'(hi), 32'd6);
        check("n6_restart_period_halves", 32'(tot), 32'd12);

        // Extremes of the divisor range.
        load(2);
        measure(hi, tot);
        measure(hi, tot);
        check("n2_high_halves", 32'(hi), 32'd2);
        check("n2_period_halves", 32'(tot), 32'd4);
        load(255);
        measure(hi, tot);
        measure(hi, tot);
        check("n255_high_halves", 32'(hi), 32'd255);
        check("n255_period_halves", 32'(tot), 32'd510);

        // Reset mid-high-phase of N=7 with 9 pending.
        load(7);
        measure(hi, tot);
        measure(hi, tot);
        check("n7_high_halves", 32'(hi), 32'd7);
        load(9);
        rst_n = 1'b0;
        @(negedge clkin);
        #2;
        check("rst_clkout_low", 32'(clkout), 32'd0);
        @(negedge clkin);
        rst_n = 1'b1;
        @(negedge clkin);
        check("rst_cur_div", 32'(cur_div), 32'd3);
        for (int i = 0; i < 12; i++) begin
            @(posedge clkin);
            #2;
            check("rst_no_ack", 32'(div_ack), 32'd0);
        end
        check("rst_keeps_default", 32'(cur_div), 32'd3);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clkin);
            if ($urandom_range(0, 39) == 0) en = ~en;
            div_load = ($urandom_range(0, 7) == 0);
            k = int'($urandom_range(0, 19));
            if (k < 14)      div_in = DIV_W'(k);
            else if (k < 19) div_in = DIV_W'($urandom_range(14, 40));
            else             div_in = 8'd255;
            rst_n = ($urandom_range(0, 599) != 0);
        end
        @(negedge clkin);
        rst_n = 1'b1; div_load = 1'b0;
        repeat (5) @(negedge clkin);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
